// File: rtl/vga_compositor.sv
// rtl/vga_compositor.sv - VGA output stage: window coordinates, sync/pixel alignment, N-layer compositing
// Optional feature: define VGA_COMPOSITOR_BORDER_EN to draw an all-ones camera-window border.
module vga_compositor #(
   parameter int PIX_W = 4,
   parameter int LAYERS = 2,
   parameter int LAYER_LAT = 3,
   parameter int WIN_X = 200,
   parameter int WIN_Y = 250,
   parameter int WIN_W = 320,
   parameter int WIN_H = 240,
   parameter logic [3*PIX_W-1:0] BG = '0,
   parameter bit SYNC_INV = 1'b1
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [10:0]                hcount_in,
   input  logic [9:0]                 vcount_in,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic                       blank_in,
   input  logic [1:0]                 mode_in,
   input  logic [LAYERS*3*PIX_W-1:0]  layer_pixel_in,
   input  logic [LAYERS-1:0]          layer_key_in,
   output logic [10:0]                win_hcount_out,
   output logic [9:0]                 win_vcount_out,
   output logic                       win_valid_out,
   output logic [PIX_W-1:0]           vga_r_out,
   output logic [PIX_W-1:0]           vga_g_out,
   output logic [PIX_W-1:0]           vga_b_out,
   output logic                       vga_hs_out,
   output logic                       vga_vs_out,
   output logic [1:0]                 mode_active_out,
   output logic                       mode_switch_out,
   output logic [15:0]                frame_count_out
);
   localparam int CW = 3*PIX_W;
`ifdef VGA_COMPOSITOR_BORDER_EN
   localparam int DW = 7;
`else
   localparam int DW = 6;
`endif

   typedef enum logic {IDLE, PENDING} state_t;

   state_t        state;
   logic          vs_prev;
   logic          armed;
   logic          vs_rise;
   logic          apply;
   logic [1:0]    mode_next;
   logic [10:0]   win_h;
   logic [9:0]    win_v;
   logic          in_win;
   logic [DW-1:0] stage_w;
   logic [DW-1:0] pipe [0:LAYER_LAT];
   logic [DW-1:0] al;
   logic [CW-1:0] pix_sel;
   logic [CW-1:0] or_acc;
   logic          any_key;

   assign win_h  = hcount_in - 11'(WIN_X);
   assign win_v  = vcount_in - 10'(WIN_Y);
   assign in_win = (32'(hcount_in) >= 32'(WIN_X)) && (32'(hcount_in) < 32'(WIN_X + WIN_W)) &&
                   (32'(vcount_in) >= 32'(WIN_Y)) && (32'(vcount_in) < 32'(WIN_Y + WIN_H));

   // No edge is seen on the first cycle out of reset, since vs_prev is meaningless there.
   assign vs_rise   = armed && vsync_in && !vs_prev;
   assign apply     = (state == PENDING) && vs_rise && (mode_in != mode_active_out);
   assign mode_next = apply ? mode_in : mode_active_out;

   // Each pixel carries the mode it entered under, so a switch lands on a frame boundary.
`ifdef VGA_COMPOSITOR_BORDER_EN
   logic on_edge;
   assign on_edge = in_win && (win_h == 11'd0 || win_h == 11'(WIN_W-1) ||
                               win_v == 10'd0 || win_v == 10'(WIN_H-1));
   assign stage_w = {on_edge, mode_next, in_win, blank_in, vsync_in, hsync_in};
`else
   assign stage_w = {mode_next, in_win, blank_in, vsync_in, hsync_in};
`endif

   assign al = pipe[LAYER_LAT];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i <= LAYER_LAT; i++) pipe[i] <= '0;
         win_hcount_out <= '0;
         win_vcount_out <= '0;
         win_valid_out  <= 1'b0;
      end else begin
         pipe[0] <= stage_w;
         for (int i = 1; i <= LAYER_LAT; i++) pipe[i] <= pipe[i-1];
         win_hcount_out <= win_h;
         win_vcount_out <= win_v;
         win_valid_out  <= in_win;
      end
   end

   always_comb begin
      pix_sel = BG;
      or_acc  = '0;
      any_key = 1'b0;
      if (layer_key_in[0] && al[3]) begin
         or_acc  = layer_pixel_in[0 +: CW];
         any_key = 1'b1;
      end
      for (int i = 1; i < LAYERS; i++) begin
         if (layer_key_in[i]) begin
            or_acc  = or_acc | layer_pixel_in[i*CW +: CW];
            any_key = 1'b1;
         end
      end
      case (al[5:4])
         2'd0: begin
            if (layer_key_in[0] && al[3]) pix_sel = layer_pixel_in[0 +: CW];
            for (int i = 1; i < LAYERS; i++)
               if (layer_key_in[i]) pix_sel = layer_pixel_in[i*CW +: CW];
         end
         2'd1: if (al[3]) pix_sel = layer_pixel_in[0 +: CW];
         2'd2: if (any_key) pix_sel = or_acc;
         default: pix_sel = BG;
      endcase
`ifdef VGA_COMPOSITOR_BORDER_EN
      if (al[6] && al[5:4] != 2'd3) pix_sel = '1;
`endif
      if (al[2]) pix_sel = '0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         {vga_r_out, vga_g_out, vga_b_out} <= '0;
         vga_hs_out <= SYNC_INV;
         vga_vs_out <= SYNC_INV;
      end else begin
         {vga_r_out, vga_g_out, vga_b_out} <= pix_sel;
         vga_hs_out <= al[0] ^ SYNC_INV;
         vga_vs_out <= al[1] ^ SYNC_INV;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         mode_active_out <= 2'd0;
         mode_switch_out <= 1'b0;
         frame_count_out <= 16'd0;
         vs_prev         <= 1'b0;
         armed           <= 1'b0;
      end else begin
         vs_prev         <= vsync_in;
         armed           <= 1'b1;
         mode_switch_out <= apply;
         mode_active_out <= mode_next;
         if (vs_rise) frame_count_out <= frame_count_out + 16'd1;
         case (state)
            IDLE:    if (mode_in != mode_active_out) state <= PENDING;
            PENDING: if (mode_in == mode_active_out || vs_rise) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/vga_compositor.md
# vga_compositor

Parametrised VGA output stage: replaces the hand-built sync/blank delay chains, hard-coded camera-window offsets and two-way pixel OR at the end of the 65 MHz video path. Generates window-relative coordinates for frame-buffer address generation, aligns hsync/vsync/blank with layer pixels returned after a configurable latency, and composites N layers under a mode that changes only at frame boundaries. Drives the VGA RGB and sync pins directly.

## Interface
Parameters:
- PIX_W, 4, bits per colour channel
- LAYERS, 2, layer count (2..8); layer 0 = camera, 1..LAYERS-1 = overlays
- LAYER_LAT, 3, cycles from win_*_out to matching layer_pixel_in/layer_key_in (0..15)
- WIN_X, 200, camera window left edge (hcount)
- WIN_Y, 250, camera window top edge (vcount)
- WIN_W, 320, window width
- WIN_H, 240, window height
- BG, 0, background colour, 3*PIX_W bits {r,g,b}
- SYNC_INV, 1, 1 = sync outputs inverted (active-low pins)

Ports:
- clk_in  in  1  pixel clock (65 MHz)
- rst_in  in  1  synchronous active-high reset
- hcount_in  in  11  pixel on current line
- vcount_in  in  10  line number
- hsync_in, vsync_in, blank_in  in  1 each  timing from vga generator
- mode_in  in  2  requested mode
- layer_pixel_in  in  LAYERS*3*PIX_W  layer i at bits [i*3*PIX_W +: 3*PIX_W], {r,g,b}
- layer_key_in  in  LAYERS  1 = layer i opaque at this pixel
- win_hcount_out  out  11  hcount_in - WIN_X
- win_vcount_out  out  10  vcount_in - WIN_Y
- win_valid_out  out  1  pixel inside window
- vga_r_out, vga_g_out, vga_b_out  out  PIX_W each
- vga_hs_out, vga_vs_out  out  1 each
- mode_active_out  out  2  mode currently applied
- mode_switch_out  out  1  one-cycle pulse when mode changes
- frame_count_out  out  16  frames since reset

## Operation
- Stage W (1 cycle): register win_hcount/win_vcount (modulo 2^11/2^10 subtraction), win_valid = WIN_X <= h < WIN_X+WIN_W and WIN_Y <= v < WIN_Y+WIN_H.
- Delay line: hsync, vsync, blank, win_valid delayed LAYER_LAT further cycles to align with layer inputs.
- Composite stage (registered), blank -> all RGB zero; else by mode_active:
  - 0 OVERLAY: highest-index overlay with key=1; else layer 0 if key=1 and win_valid; else BG.
  - 1 CAMERA: layer 0 if win_valid, ignoring key; else BG.
  - 2 OR: bitwise OR of all keyed layers (layer 0 only if win_valid); BG if none keyed.
  - 3 BLANK: BG.
- Mode FSM: IDLE, PENDING. IDLE: mode_in != mode_active -> latch req, PENDING. PENDING: on vsync_in rising edge apply latched req (latest mode_in sampled that cycle), pulse mode_switch_out, -> IDLE; if mode_in returns to mode_active before edge -> IDLE, no pulse.
- frame_count_out increments on every vsync_in rising edge, wraps 0xFFFF -> 0; same edge as mode apply.

## Timing
- win_*_out latency 1 from hcount_in/vcount_in.
- RGB and sync outputs latency LAYER_LAT+2 from hcount_in; sync and RGB of one pixel leave on the same cycle.
- vga_hs_out = delayed hsync XOR SYNC_INV; same for vs.
- Mode change visible on the first composited pixel whose vsync entered at/after the applying edge; mode_switch_out, mode_active_out, frame_count_out update 1 cycle after the vsync_in rising edge.
- Reset: all pipeline registers 0; RGB 0; vga_hs_out = vga_vs_out = SYNC_INV; win outputs 0; mode_active 0; FSM IDLE; mode_switch_out 0; frame_count_out 0. Reset mid-frame discards pending request; no vsync edge detected on first cycle after reset.
- Simultaneous mode_in change and vsync edge while IDLE: change waits for next edge.

## Configuration
- VGA_COMPOSITOR_BORDER_EN defined: pixel on window perimeter (win_valid and win_h in {0,WIN_W-1} or win_v in {0,WIN_H-1}) forced to all-ones in modes 0-2, above all layers; mode 3 unaffected. Undefined: no border logic, perimeter composited normally.

## Test plan
- Reset, then hcount=200,vcount=250 -> win_*_out = 0/0, win_valid=1 one cycle later; hcount=520 -> win_valid=0.
- LAYER_LAT=3, drive vsync pulse -> vga_vs_out toggles exactly 5 cycles later, inverted; blank=1 forces RGB 0 with keys all 1.
- Mode 0, LAYERS=3, layer1=0x0F0 key1, layer2=0xF00 key1 -> output 0xF00; key2=0 -> 0x0F0; both 0, in window, layer0 key=1 0x888 -> 0x888.
- Mode 2, layer0=0x111 (in window, key1), layer1=0x0F0 key1 -> 0x1F1; out of window -> 0x0F0.
- mode_in 0->2 mid-frame -> output unchanged until vsync rise, then mode_switch_out one pulse, mode_active=2, frame_count +1; 0->2->0 before edge -> no pulse.
- With BORDER_EN, pixel (200,300) in mode 1 -> 0xFFF; frame_count at 0xFFFF plus one vsync -> 0.
